bus_trace_monitor: RTL

- Synthesizable successor to the bench-only bus printer: captures completed CPU bus transactions (instruction fetch, read, write) into a parametrised circular trace buffer.
- Filtering is by transaction type and by an inclusive address window. An optional address trigger can start capture.
- Sits beside the picorv32 system bus and taps the same qualifier, rw_cycle AND rw_is_done.
- Drained by a simple show-ahead pop interface, intended for a later memory-mapped debug peripheral or a bench checker.

---
 rtl/trace_pkg.sv | 45 ++++
 rtl/trace_ring.sv | 76 +++++++
 rtl/bus_trace_monitor.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/trace_pkg.sv
// Shared encodings and entry layout for the bus trace monitor.
// Entry layout is fixed here so that the ring and any future drain logic agree on the field positions.
package trace_pkg;

    localparam int unsigned TYPE_W   = 2;
    localparam int unsigned TSTAMP_W = 32;

    typedef enum logic [1:0] {
        TR_IFETCH = 2'd0,
        TR_READ   = 2'd1,
        TR_WRITE  = 2'd2
    } tr_type_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } tr_state_e;

    // Field order inside an entry, LSB first: type | addr | data | wstrb | tstamp
    localparam int unsigned OFF_TYPE = 0;

    function automatic int unsigned off_addr();
        return TYPE_W;
    endfunction

    function automatic int unsigned off_data(input int unsigned aw);
        return TYPE_W + aw;
    endfunction

    function automatic int unsigned off_wstrb(input int unsigned aw, input int unsigned dw);
        return TYPE_W + aw + dw;
    endfunction

    function automatic int unsigned off_tstamp(input int unsigned aw, input int unsigned dw);
        return TYPE_W + aw + dw + dw / 8;
    endfunction

    function automatic int unsigned entry_w(input int unsigned aw, input int unsigned dw,
                                            input int unsigned ts_en);
        return off_tstamp(aw, dw) + ((ts_en != 0) ? TSTAMP_W : 0);
    endfunction

endpackage

// File: rtl/trace_ring.sv
// Circular DEPTH-entry register file with show-ahead head and overwrite-on-full.
// A push into a full ring always drops the oldest entry; the caller decides whether that is allowed.
module trace_ring #(
    parameter int unsigned EW    = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  logic [EW-1:0]            wdata,
    output logic [EW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] cnt;

    logic do_pop;
    logic over;
    logic inc;
    logic dec;
    logic rd_adv;

    always_comb begin
        full   = (cnt == CW'(DEPTH));
        empty  = (cnt == '0);
        do_pop = pop && !empty;
        over   = push && full;
        inc    = push && !full;
        dec    = do_pop && !over;
        rd_adv = do_pop || over;
        head   = mem[rd_ptr];
        count  = cnt;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (inc && !dec) begin
                cnt <= cnt + CW'(1);
            end else if (dec && !inc) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clr) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/bus_trace_monitor.sv
// Captures filtered CPU bus transactions into a circular trace buffer drained by a show-ahead pop port.
// Define TRACE_TIMESTAMP_EN to store a free-running cycle stamp per entry on out_tstamp.
module bus_trace_monitor
    import trace_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned OVF_W  = 16
) (
    input  logic                     sys_clk,
    input  logic                     sys_resetn,
    input  logic                     mon_valid,
    input  logic                     mon_instr,
    input  logic [DATA_W/8-1:0]      mon_wstrb,
    input  logic [ADDR_W-1:0]        mon_addr,
    input  logic [DATA_W-1:0]        mon_wdata,
    input  logic [DATA_W-1:0]        mon_rdata,
    input  logic                     cfg_enable,
    input  logic                     cfg_wrap,
    input  logic [2:0]               cfg_type_mask,
    input  logic [ADDR_W-1:0]        cfg_addr_lo,
    input  logic [ADDR_W-1:0]        cfg_addr_hi,
    input  logic                     cfg_trig_en,
    input  logic [ADDR_W-1:0]        cfg_trig_addr,
    input  logic                     clr,
    input  logic                     pop,
    output logic                     out_valid,
    output logic [1:0]               out_type,
    output logic [ADDR_W-1:0]        out_addr,
    output logic [DATA_W-1:0]        out_data,
    output logic [DATA_W/8-1:0]      out_wstrb,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic [OVF_W-1:0]         ovf_cnt,
    output logic [1:0]               state
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [TSTAMP_W-1:0]      out_tstamp
`endif
);

    localparam int unsigned SW = DATA_W / 8;
    localparam int unsigned CW = $clog2(DEPTH) + 1;
`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned TS_EN = 1;
`else
    localparam int unsigned TS_EN = 0;
`endif
    localparam int unsigned OFF_ADDR  = off_addr();
    localparam int unsigned OFF_DATA  = off_data(ADDR_W);
    localparam int unsigned OFF_WSTRB = off_wstrb(ADDR_W, DATA_W);
    localparam int unsigned EW        = entry_w(ADDR_W, DATA_W, TS_EN);

    tr_state_e       st;
    tr_type_e        ev_type;
    logic [DATA_W-1:0] ev_data;
    logic            in_window;
    logic            match;
    logic            trig_hit;
    logic            cap_match;
    logic            push;
    logic            freeze;
    logic            ovf_event;
    logic [EW-1:0]   entry_in;
    logic [EW-1:0]   head;
    logic [CW-1:0]   ring_count;
    logic            ring_full;
    logic            ring_empty;

`ifdef TRACE_TIMESTAMP_EN
    localparam int unsigned OFF_TS = off_tstamp(ADDR_W, DATA_W);
    logic [TSTAMP_W-1:0] ts_cnt;

    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            ts_cnt <= '0;
        end else if (clr) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + TSTAMP_W'(1);
        end
    end
`endif

    // Classification, filtering and the push/overflow decision for this cycle's event.
    always_comb begin
        ev_type = TR_READ;
        if (mon_instr) begin
            ev_type = TR_IFETCH;
        end else if (|mon_wstrb) begin
            ev_type = TR_WRITE;
        end
        ev_data   = (ev_type == TR_WRITE) ? mon_wdata : mon_rdata;
        in_window = (mon_addr >= cfg_addr_lo) && (mon_addr <= cfg_addr_hi);
        match     = mon_valid && cfg_type_mask[ev_type] && in_window;
        trig_hit  = match && (mon_addr == cfg_trig_addr);
        cap_match = cfg_enable && !clr &&
                    (((st == ST_CAPTURE) && match) || ((st == ST_ARMED) && trig_hit));
        // A pop frees the slot in the same cycle, so a full non-wrapping ring still accepts.
        push      = cap_match && (!ring_full || cfg_wrap || pop);
        freeze    = cap_match && ring_full && !cfg_wrap && !pop;
        ovf_event = (cap_match && ring_full && (cfg_wrap || !pop)) ||
                    (cfg_enable && (st == ST_FROZEN) && match);

        entry_in = '0;
        entry_in[OFF_TYPE +: TYPE_W]   = ev_type;
        entry_in[OFF_ADDR +: ADDR_W]   = mon_addr;
        entry_in[OFF_DATA +: DATA_W]   = ev_data;
        entry_in[OFF_WSTRB +: SW]      = mon_wstrb;
`ifdef TRACE_TIMESTAMP_EN
        entry_in[OFF_TS +: TSTAMP_W]   = ts_cnt;
`endif
    end

    trace_ring #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_ring (
        .clk   (sys_clk),
        .rst_n (sys_resetn),
        .clr   (clr),
        .push  (push),
        .pop   (pop),
        .wdata (entry_in),
        .head  (head),
        .count (ring_count),
        .full  (ring_full),
        .empty (ring_empty)
    );

    // Capture FSM and saturating overflow counter.
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            st      <= ST_IDLE;
            ovf_cnt <= '0;
        end else if (clr) begin
            st      <= ST_IDLE;
            ovf_cnt <= '0;
        end else begin
            if (ovf_event && (ovf_cnt != '1)) begin
                ovf_cnt <= ovf_cnt + OVF_W'(1);
            end
            if (!cfg_enable) begin
                st <= ST_IDLE;
            end else begin
                case (st)
                    ST_IDLE:    st <= cfg_trig_en ? ST_ARMED : ST_CAPTURE;
                    ST_ARMED: begin
                        if (trig_hit) begin
                            st <= freeze ? ST_FROZEN : ST_CAPTURE;
                        end
                    end
                    ST_CAPTURE: begin
                        if (freeze) begin
                            st <= ST_FROZEN;
                        end
                    end
                    ST_FROZEN: begin
                        if (!ring_full) begin
                            st <= ST_CAPTURE;
                        end
                    end
                    default:    st <= ST_IDLE;
                endcase
            end
        end
    end

    // Head fields read as zero while empty since storage itself is never reset.
    always_comb begin
        out_valid = !ring_empty;
        out_type  = out_valid ? head[OFF_TYPE +: TYPE_W]  : '0;
        out_addr  = out_valid ? head[OFF_ADDR +: ADDR_W]  : '0;
        out_data  = out_valid ? head[OFF_DATA +: DATA_W]  : '0;
        out_wstrb = out_valid ? head[OFF_WSTRB +: SW]     : '0;
`ifdef TRACE_TIMESTAMP_EN
        out_tstamp = out_valid ? head[OFF_TS +: TSTAMP_W] : '0;
`endif
        count     = ring_count;
        full      = ring_full;
        state     = st;
    end

endmodule
